fault_index_decoder: RTL and testbench
======================================

# fault_index_decoder

Sequential decoder for the BISR weight-proxy repair path. It accepts a stream of encoded faulty-PE indices from BIST over a valid/ready handshake and decodes each one into a fault bitmap. It counts distinct faults and reports, once BIST signals completion, whether the spare PEs can cover them. The bitmap polarity matches `priority_encoder`, so `map_out` can be fed straight back into that encoder during repair.

## Interface
- `OUTPUT_WIDTH`, 4: number of PEs, which is the bitmap width.
- `NUM_SPARES`, 1: spare PEs available for repair.
- `ENCODED_VAL`, 0: bit value written at a faulty index; healthy bits hold `!ENCODED_VAL`.
- Localparam `IDX_WIDTH = $clog2(OUTPUT_WIDTH)`.
- Localparam `CNT_WIDTH = $clog2(OUTPUT_WIDTH+1)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart; highest priority after reset.
- `idx_valid`  in  1  `idx_in` holds a fault index.
- `idx_ready`  out  1  block can accept an index.
- `idx_in`  in  `IDX_WIDTH`  encoded faulty PE index.
- `done`  in  1  BIST finished; single-cycle pulse or level.
- `map_out`  out  `OUTPUT_WIDTH`  fault bitmap.
- `fault_count`  out  `CNT_WIDTH`  number of distinct faults recorded.
- `map_valid`  out  1  map and verdict are final.
- `repairable`  out  1  `fault_count <= NUM_SPARES`; meaningful only while `map_valid` is high.
- `range_err`  out  1  sticky flag: an out-of-range index was received.

## Operation
FSM with two states: COLLECT and FINAL.

COLLECT:
- `idx_ready` = 1.
- Transfer occurs when `idx_valid && idx_ready`.
- If bit `idx_in` of `map_out` already equals `ENCODED_VAL`, the index is a duplicate: map and count are unchanged.
- Otherwise the bit is set to `ENCODED_VAL` and `fault_count` increments.
- `fault_count` never exceeds `OUTPUT_WIDTH`, so it cannot wrap.
- `done` = 1 moves the FSM to FINAL.
- A transfer and `done` in the same cycle: the index is recorded, then the FSM enters FINAL.

FINAL:
- `idx_ready` = 0 and `map_valid` = 1.
- Map, count and `range_err` are frozen; `idx_valid` and `done` are ignored.
- Exit only via `clear` or reset.

`clear`:
- Map returns to all `!ENCODED_VAL`; count = 0; `range_err` = 0; FSM goes to COLLECT.
- Any transfer or `done` in the same cycle is discarded.

Reset values (asynchronous, while `rst_n` = 0):
- FSM = COLLECT.
- `map_out` = {`OUTPUT_WIDTH`{`!ENCODED_VAL`}}.
- `fault_count` = 0, `map_valid` = 0, `range_err` = 0.
- `idx_ready` = 0 while in reset, 1 from the first edge after release.
- `repairable` = 1 (count 0 ≤ `NUM_SPARES`).

Reset mid-collection: all partial results are discarded.

## Timing
- `map_out` and `fault_count` update on the edge that completes the transfer; visible the next cycle; latency 1.
- `idx_ready` and `map_valid` are registered FSM decodes:
  - `map_valid` rises 1 cycle after `done` is sampled in COLLECT.
  - `idx_ready` falls in that same cycle.
- `repairable` is combinational from `fault_count`.
- One index accepted per cycle, back-to-back.

## Configuration
Macro `FAULT_MAP_RANGE_CHECK_EN`.

Defined:
- An index ≥ `OUTPUT_WIDTH` is still handshaken (`idx_ready` honored), but the map and count are unchanged.
- `range_err` sets on the next edge and stays set until `clear` or reset.

Undefined:
- No check is performed and `range_err` is tied 0.
- An out-of-range index sets no map bit but increments `fault_count` (saturating at `OUTPUT_WIDTH`), which can cause `repairable` = 0.

The check only matters when `OUTPUT_WIDTH` is not a power of two.

## Test plan
All scenarios use `OUTPUT_WIDTH`=4, `NUM_SPARES`=1, `ENCODED_VAL`=0 unless stated.

1. Reset release, then index 2 transferred, then `done` pulse:
   - `map_out` = 4'b1011, `fault_count` = 1.
   - `map_valid` = 1 one cycle after `done`; `repairable` = 1; `idx_ready` = 0.
2. Indices 0, 3, 0 back-to-back, then `done`:
   - `map_out` = 4'b0110, `fault_count` = 2 (duplicate ignored), `repairable` = 0.
3. Index 1 with `done` in the same cycle, then index 2 offered in FINAL:
   - `map_out` = 4'b1101, `fault_count` = 1; the second index is not accepted.
   - Then `clear`: `map_out` = 4'b1111, count 0, `map_valid` = 0, `idx_ready` = 1.
4. `rst_n` asserted asynchronously mid-stream after indices 1 and 2:
   - Outputs go to reset values immediately, without waiting for a clock edge.
5. `OUTPUT_WIDTH`=6, `ENCODED_VAL`=1, index 7 then index 5, macro defined:
   - `range_err` = 1, `map_out` = 6'b100000, `fault_count` = 1.
   - Same stimulus with the macro undefined: `range_err` = 0, `fault_count` = 2.

Source files
------------

// File: rtl/fault_index_decoder.sv
// Streams BIST faulty-PE indices into a fault bitmap with a distinct-fault count and spare-coverage verdict.
// Optional out-of-range index check enabled by defining FAULT_MAP_RANGE_CHECK_EN.
module fault_index_decoder #(
    parameter int OUTPUT_WIDTH = 4,
    parameter int NUM_SPARES   = 1,
    parameter bit ENCODED_VAL  = 1'b0,
    localparam int IDX_WIDTH   = $clog2(OUTPUT_WIDTH),
    localparam int CNT_WIDTH   = $clog2(OUTPUT_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    idx_valid,
    output logic                    idx_ready,
    input  logic [IDX_WIDTH-1:0]    idx_in,
    input  logic                    done,
    output logic [OUTPUT_WIDTH-1:0] map_out,
    output logic [CNT_WIDTH-1:0]    fault_count,
    output logic                    map_valid,
    output logic                    repairable,
    output logic                    range_err
);

`ifdef FAULT_MAP_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic {COLLECT = 1'b0, FINAL = 1'b1} state_t;

    state_t                  state;
    logic [OUTPUT_WIDTH-1:0] fault_q;
    logic [OUTPUT_WIDTH-1:0] hit;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    rerr_q;
    logic                    in_range;
    logic                    dup;
    logic                    inc;
    logic                    xfer;

    // Faults are tracked active-high internally; polarity is applied only at the output.
    always_comb begin
        hit      = '0;
        in_range = (32'(idx_in) < OUTPUT_WIDTH);
        for (int i = 0; i < OUTPUT_WIDTH; i++)
            hit[i] = (32'(idx_in) == i);
        dup  = |(hit & fault_q);
        xfer = idx_valid && idx_ready;
        inc  = in_range ? !dup : !RANGE_CHK;
    end

    assign map_out     = ENCODED_VAL ? fault_q : ~fault_q;
    assign fault_count = cnt_q;
    assign repairable  = (32'(cnt_q) <= NUM_SPARES);
    assign range_err   = rerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            fault_q   <= '0;
            cnt_q     <= '0;
            rerr_q    <= 1'b0;
            idx_ready <= 1'b0;
            map_valid <= 1'b0;
        end else if (clear) begin
            state     <= COLLECT;
            fault_q   <= '0;
            cnt_q     <= '0;
            rerr_q    <= 1'b0;
            idx_ready <= 1'b1;
            map_valid <= 1'b0;
        end else if (state == COLLECT) begin
            if (xfer) begin
                fault_q <= fault_q | hit;
                // Saturate so an unchecked out-of-range stream cannot wrap the count.
                if (inc && cnt_q != CNT_WIDTH'(OUTPUT_WIDTH))
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                if (!in_range && RANGE_CHK)
                    rerr_q <= 1'b1;
            end
            if (done) begin
                state     <= FINAL;
                idx_ready <= 1'b0;
                map_valid <= 1'b1;
            end else begin
                idx_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fault_index_decoder.sv
// Scoreboard bench for fault_index_decoder: queued per-cycle expectations from a fault-set model.
module tb_fault_index_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       idx_valid = 1'b0;
    logic       done = 1'b0;
    logic [1:0] idx_in = '0;
    logic       idx_ready, map_valid, repairable, range_err;
    logic [3:0] map_out;
    logic [2:0] fault_count;

    logic       r6 = 1'b0, v6 = 1'b0, d6 = 1'b0, c6 = 1'b0;
    logic [2:0] i6 = '0;
    logic       rdy6, mv6, rep6, rerr6;
    logic [5:0] map6;
    logic [2:0] cnt6;

    int n_checks = 0;
    int n_fail   = 0;

    fault_index_decoder dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .idx_valid(idx_valid),
        .idx_ready(idx_ready), .idx_in(idx_in), .done(done), .map_out(map_out),
        .fault_count(fault_count), .map_valid(map_valid), .repairable(repairable),
        .range_err(range_err)
    );

    fault_index_decoder #(.OUTPUT_WIDTH(6), .NUM_SPARES(1), .ENCODED_VAL(1'b1)) dut6 (
        .clk(clk), .rst_n(r6), .clear(c6), .idx_valid(v6),
        .idx_ready(rdy6), .idx_in(i6), .done(d6), .map_out(map6),
        .fault_count(cnt6), .map_valid(mv6), .repairable(rep6),
        .range_err(rerr6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] map;
        logic [2:0] cnt;
        logic       rdy, mv, rep, rerr;
    } snap_t;

    snap_t exp_q[$];
    int    faults[$];
    bit    m_final = 1'b0;
    bit    m_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.map = 4'b1111;
        foreach (faults[k]) s.map[faults[k]] = 1'b0;
        s.cnt  = 3'(faults.size());
        s.rdy  = m_ready;
        s.mv   = m_final;
        s.rep  = (faults.size() <= 1);
        s.rerr = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs and record what the design must show after the next edge.
    task automatic step(input bit r, input bit v, input int idx, input bit d, input bit c);
        bit seen;
        @(negedge clk);
        rst_n = r; idx_valid = v; idx_in = 2'(idx); done = d; clear = c;
        if (!r) begin
            faults.delete(); m_final = 1'b0; m_ready = 1'b0;
        end else if (c) begin
            faults.delete(); m_final = 1'b0; m_ready = 1'b1;
        end else if (!m_final) begin
            if (v && m_ready) begin
                seen = 1'b0;
                foreach (faults[k]) if (faults[k] == idx) seen = 1'b1;
                if (!seen) faults.push_back(idx);
            end
            if (d) begin m_final = 1'b1; m_ready = 1'b0; end
            else m_ready = 1'b1;
        end
        exp_q.push_back(snap());
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".map"}, 32'(map_out), 32'hF);
        chk({tag, ".cnt"}, 32'(fault_count), 0);
        chk({tag, ".rdy"}, 32'(idx_ready), 0);
        chk({tag, ".mv"},  32'(map_valid), 0);
        chk({tag, ".rep"}, 32'(repairable), 1);
        chk({tag, ".rerr"}, 32'(range_err), 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        faults.delete(); m_final = 1'b0; m_ready = 1'b0;
    endtask

    always @(posedge clk) begin
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("map_out",     32'(map_out),     32'(e.map));
            chk("fault_count", 32'(fault_count), 32'(e.cnt));
            chk("idx_ready",   32'(idx_ready),   32'(e.rdy));
            chk("map_valid",   32'(map_valid),   32'(e.mv));
            chk("repairable",  32'(repairable),  32'(e.rep));
            chk("range_err",   32'(range_err),   32'(e.rerr));
        end
    end

    initial begin
        #1 check_reset_vals("por");

        // Width-6 active-high instance: out-of-range index 7, then index 5.
        @(negedge clk); r6 = 1'b1;
        @(negedge clk); v6 = 1'b1; i6 = 3'd7;
        @(negedge clk); i6 = 3'd5;
        @(negedge clk); v6 = 1'b0;
        chk("w6.map", 32'(map6), 32'h20);
`ifdef FAULT_MAP_RANGE_CHECK_EN
        chk("w6.rerr", 32'(rerr6), 1);
        chk("w6.cnt",  32'(cnt6), 1);
        chk("w6.rep",  32'(rep6), 1);
`else
        chk("w6.rerr", 32'(rerr6), 0);
        chk("w6.cnt",  32'(cnt6), 2);
        chk("w6.rep",  32'(rep6), 0);
`endif

        // Reset release, index 2, done.
        step(0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 2, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // Back-to-back with a duplicate.
        step(1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 3, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // Index with done in the same cycle, then an index offered in FINAL, then clear.
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 0);
        step(1, 1, 2, 0, 0);
        step(1, 1, 3, 1, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // Async reset mid-stream.
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 0, 0);
        async_reset();
        step(0, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) async_reset();
            step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 60),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 5));
        end

        step(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
